// File: rtl/pir_display_scan.sv
// pir_display_scan: multiplexed 4-digit common-anode 7-segment driver with frame-aligned latching and buzzer blink.
// Optional build macro DISPLAY_HEX_DECODE_EN: bytes carry {dp,-,-,blank,hex} instead of raw segment patterns.
module pir_display_scan #(
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display_data,
  input  logic [2:0]  LED,
  input  logic        buzzer,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_N = CNT_W'(BLANK_CYCLES);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             frame_end;
  logic             visible;
  logic [7:0]       byte_sel;
  logic [7:0]       pattern;
  logic [3:0]       led_ext;

`ifdef DISPLAY_HEX_DECODE_EN
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] g;
    g = 7'h00;
    case (h)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  logic hex_unused;
  assign hex_unused = ^byte_sel[6:5];
`endif

  assign led_ext = {1'b0, LED};

  always_comb begin
    frame_end    = (cnt_q == CNT_MAX) && (digit_q == 2'd3);
    cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    digit_d      = (cnt_q == CNT_MAX) ? digit_q + 2'd1 : digit_q;
    shadow_d     = frame_end ? display_data : shadow_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    if (frame_end) begin
      if (!buzzer) begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Outputs are computed from next-state values so they line up with cnt/digit.
    byte_sel = shadow_d[{digit_d, 3'b000} +: 8];
`ifdef DISPLAY_HEX_DECODE_EN
    pattern  = {byte_sel[7], byte_sel[4] ? 7'h00 : hex_glyph(byte_sel[3:0])};
`else
    pattern  = byte_sel;
`endif
    pattern[7]   = pattern[7] | led_ext[digit_d];
    visible      = (cnt_d >= BLANK_N) && blink_on_d;
    an_d         = visible ? ~(4'b0001 << digit_d) : 4'hF;
    seg_d        = visible ? ~pattern : 8'hFF;
    frame_done_d = (cnt_d == CNT_MAX) && (digit_d == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      shadow_q     <= 32'h0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      seg_q        <= 8'hFF;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_pir_display_scan.sv
// Bench for pir_display_scan: directed plan phases plus random traffic against a cycle-index reference model.
module tb_pir_display_scan;
  localparam int SCAN_DIV     = 16;
  localparam int BLANK_CYCLES = 2;
  localparam int BLINK_FRAMES = 4;
  localparam int FRAME        = 4 * SCAN_DIV;
  localparam logic [7:0] HEX_TBL [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] display_data;
  logic [2:0]  led;
  logic        buzzer;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycle index since reset, captured word, consecutive buzzer frame ends.
  int          m_t;
  logic [31:0] m_shadow;
  int          m_run;
  logic [12:0] exp_q[$];

  pir_display_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .rst_n(rst_n), .display_data(display_data), .LED(led), .buzzer(buzzer),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %h expected %h", tag, m_t, got, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [7:0] b);
`ifdef DISPLAY_HEX_DECODE_EN
    logic [7:0] g;
    g = HEX_TBL[b[3:0]];
    return {b[7], b[4] ? 7'h00 : g[6:0]};
`else
    return b;
`endif
  endfunction

  function automatic logic [12:0] model_out();
    int pos, d;
    logic [7:0] p;
    logic vis;
    pos = m_t % SCAN_DIV;
    d   = (m_t / SCAN_DIV) % 4;
    vis = (pos >= BLANK_CYCLES) && ((m_run / BLINK_FRAMES) % 2 == 0);
    p   = glyph(m_shadow[8*d +: 8]);
    if (d < 3 && led[d]) p[7] = 1'b1;
    return {(m_t % FRAME == FRAME - 1), vis ? ~(4'b0001 << d) : 4'hF, vis ? ~p : 8'hFF};
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_shadow = 32'h0;
    m_run = 0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [31:0] dd, input logic [2:0] l, input logic bz);
    logic [12:0] e;
    display_data = dd;
    led = l;
    buzzer = bz;
    @(posedge clk);
    if (m_t % FRAME == FRAME - 1) begin
      m_shadow = display_data;
      m_run = buzzer ? m_run + 1 : 0;
    end
    m_t++;
    exp_q.push_back(model_out());
    #1;
    e = exp_q.pop_front();
    check("frame_done", {31'b0, frame_done}, {31'b0, e[12]});
    check("an", {28'b0, an}, {28'b0, e[11:8]});
    check("seg", {24'b0, seg}, {24'b0, e[7:0]});
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    check("rst_an", {28'b0, an}, 32'hF);
    check("rst_seg", {24'b0, seg}, 32'hFF);
    check("rst_fd", {31'b0, frame_done}, 32'h0);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] dd;
    logic [2:0]  l;
    logic        bz;
    int          f;
    int          c;
    rst_n = 1'b0;
    display_data = 32'hFFFF_FFFF;
    led = 3'b000;
    buzzer = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_an", {28'b0, an}, 32'hF);
    check("init_seg", {24'b0, seg}, 32'hFF);
    check("init_fd", {31'b0, frame_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed plan: empty frame, static pattern, tearing guard, LED dp, blink, mid-frame reset.
    c = 0;
    while (m_t != 23 * FRAME + 37 && c < 30 * FRAME) begin
      f  = m_t / FRAME;
      dd = (m_t < 40) ? 32'hFFFF_FFFF : (m_t < 100) ? 32'h065B4F66 : (m_t < 192) ? 32'h0 : 32'h065B4F66;
      l  = (m_t >= 192) ? 3'b101 : 3'b000;
      bz = (f >= 3 && f <= 13) || (f >= 15 && f <= 20);
      step(dd, l, bz);
      c++;
      if (m_t == 63)  check("lit_fd63", {31'b0, frame_done}, 32'h1);
      if (m_t == 518) check("lit_blink_off", {28'b0, an}, 32'hF);
`ifndef DISPLAY_HEX_DECODE_EN
      if (m_t == 72)  check("lit_d0", {24'b0, seg}, 32'h99);
      if (m_t == 88)  check("lit_d1", {24'b0, seg}, 32'hB0);
      if (m_t == 104) check("lit_tear_d2", {24'b0, seg}, 32'hA4);
      if (m_t == 120) check("lit_tear_d3", {24'b0, seg}, 32'hF9);
      if (m_t == 136) check("lit_cleared", {24'b0, seg}, 32'hFF);
      if (m_t == 264) check("lit_led_d0", {24'b0, seg}, 32'h19);
      if (m_t == 280) check("lit_led_d1", {24'b0, seg}, 32'hB0);
      if (m_t == 296) check("lit_led_d2", {24'b0, seg}, 32'h24);
      if (m_t == 312) check("lit_led_d3", {24'b0, seg}, 32'hF9);
`endif
    end
    check("reached_reset_point", m_t, 23 * FRAME + 37);
    check("pre_reset_an", {28'b0, an}, 32'hB);
    reset_pulse();

    for (int i = 0; i < 2 * FRAME; i++) begin
      step(32'h0000_1303, 3'b000, 1'b0);
`ifdef DISPLAY_HEX_DECODE_EN
      if (m_t == 72) check("hex_03", {24'b0, seg}, 32'hB0);
      if (m_t == 88) check("hex_13", {24'b0, seg}, 32'hFF);
`else
      if (m_t == 72) check("raw_03", {24'b0, seg}, 32'hFC);
      if (m_t == 88) check("raw_13", {24'b0, seg}, 32'hEC);
`endif
    end

    // Random traffic: new word every cycle, slow-moving buzzer, occasional async reset.
    bz = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 399) == 0) bz = ~bz;
      if ($urandom_range(0, 499) == 0) reset_pulse();
      step($urandom, 3'($urandom_range(0, 7)), bz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
